// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers for the AES (Inv)MixColumns stages: xtime-based constant
// multiplies, byte layout of the 128-bit state, and the shared stage FSM encoding.
package aes_gf_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned COL_W    = NUM_ROWS * BYTE_W;
  localparam int unsigned STATE_W  = NUM_COLS * COL_W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mc_state_e;

  // Byte s(r,c) lives at [byte_lsb(c,r) +: BYTE_W]; row 0 is the low byte of a column.
  function automatic int unsigned byte_lsb(input int unsigned c, input int unsigned r);
    return COL_W * c + BYTE_W * r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul02(input logic [7:0] a);
    return xtime(a);
  endfunction

  function automatic logic [7:0] gf_mul03(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on a single 32-bit column.
module inv_mix_column
  import aes_gf_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] a [NUM_ROWS];

  always_comb begin
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      a[r] = col_in[byte_lsb(0, r) +: BYTE_W];
    end
  end

  always_comb begin
    col_out = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      col_out[byte_lsb(0, r) +: BYTE_W] = gf_mul0e(a[r])
                                        ^ gf_mul0b(a[(r + 1) % NUM_ROWS])
                                        ^ gf_mul0d(a[(r + 2) % NUM_ROWS])
                                        ^ gf_mul09(a[(r + 3) % NUM_ROWS]);
    end
  end

endmodule

// File: rtl/inv_mix_columns.sv
// Sequential AES InvMixColumns: latch a state, transform COLS_PER_CYCLE columns
// per clock, then hold the result until the downstream handshake completes.
module inv_mix_columns
  import aes_gf_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [STATE_W-1:0]   data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [STATE_W-1:0]   data_out
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int unsigned NUM_GROUPS = NUM_COLS / COLS_PER_CYCLE;
  localparam logic [1:0]  LAST_GROUP = 2'(NUM_GROUPS - 1);

  mc_state_e            state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [STATE_W-1:0]   src_q, src_d;
  logic [STATE_W-1:0]   dout_q, dout_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic [1:0]           col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0]     col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]     col_out [COLS_PER_CYCLE];

  always_comb begin
    for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
      col_idx[i] = 2'(32'(cnt_q) * COLS_PER_CYCLE + i);
      col_in[i]  = src_q[COL_W * col_idx[i] +: COL_W];
    end
  end

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
    inv_mix_column u_col (
      .col_in  (col_in[gi]),
      .col_out (col_out[gi])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          src_d   = data_in;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
          dout_d[COL_W * col_idx[i] +: COL_W] = col_out[i];
        end
        // Leave on the last group explicitly so the 2-bit counter never wraps into a new pass.
        if (cnt_q == LAST_GROUP) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready && out_valid_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next state, so they are 0 in reset.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      src_q       <= '0;
      dout_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      dout_q      <= dout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = dout_q;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench: one DUT per legal COLS_PER_CYCLE, each checked against a
// matrix-level GF(2^8) model of (Inv)MixColumns.
module tb_inv_mix_columns;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit done_flag [3];

  localparam logic [127:0] KAT_IN  = 128'hd6d7d5d5_01010101_9d58dc9f_bca14d8e;
  localparam logic [127:0] KAT_OUT = 128'hd5d4d4d4_01010101_5c220af2_455313db;

  // Generic shift-and-add GF(2^8) multiply, reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  // out(r,c) = sum_j coef[j] * s((r+j) mod 4, c); inverse or forward coefficient row.
  function automatic logic [127:0] mc_model(input logic [127:0] s, input bit inv);
    logic [7:0] coef [4];
    logic [127:0] o = '0;
    logic [7:0] acc;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(coef[j], s[32*c + 8*((r+j)%4) +: 8]);
        end
        o[32*c + 8*r +: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned C = 1 << g;
    localparam int unsigned N = 4 / C;

    logic         rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] data_in, data_out;

    inv_mix_columns #(.COLS_PER_CYCLE(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out)
    );

    logic [127:0] exp_q [$];
    int unsigned  cyc = 0;
    int unsigned  acc_cyc = 0;
    int unsigned  last_hs = 0;
    bit           have_last = 0;
    bit           streaming = 0;
    bit           prev_ov = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output checker: every completed handshake must deliver the oldest expected state.
    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        prev_ov   = 0;
        have_last = 0;
      end else begin
        // Rise is seen at the negedge after edge T+N; acc_cyc was taken before edge T.
        if (out_valid && !prev_ov)
          chk($sformatf("c%0d latency", C), cyc - acc_cyc, N + 1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL c%0d spurious_output: got %h expected no output", C, data_out);
          end else begin
            chk($sformatf("c%0d data_out", C), data_out, exp_q.pop_front());
          end
          if (streaming && have_last)
            chk($sformatf("c%0d stream_interval", C), cyc - last_hs, N + 2);
          last_hs   = cyc;
          have_last = 1;
        end
        prev_ov = out_valid;
      end
    end

    task automatic send(input logic [127:0] d, input logic [127:0] e);
      int unsigned w = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      data_in  = d;
      @(negedge clk);
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        chk($sformatf("c%0d accept_timeout", C), in_ready, 1);
      end else begin
        exp_q.push_back(e);
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int unsigned w = 0;
      while (exp_q.size() != 0 && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("c%0d drain", C), exp_q.size(), 0);
    endtask

    initial begin
      logic [127:0] x, held;
      int unsigned w;
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
      #2 rst_n = 1'b0;

      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        data_in   = rand128();
        @(negedge clk);
        chk($sformatf("c%0d rst_in_ready", C), in_ready, 0);
        chk($sformatf("c%0d rst_out_valid", C), out_valid, 0);
        chk($sformatf("c%0d rst_data_out", C), data_out, '0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("c%0d in_ready_after_rst", C), in_ready, 1);

      send(KAT_IN, KAT_OUT);
      drain();

      // Backpressure: result must hold while new inputs are waved at the block.
      out_ready = 1'b0;
      x = rand128();
      send(x, mc_model(x, 1));
      w = 0;
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("c%0d bp_out_valid_rise", C), out_valid, 1);
      held = data_out;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        in_valid = ~in_valid;
        data_in  = rand128();
        @(negedge clk);
        chk($sformatf("c%0d bp_data_hold", C), data_out, held);
        chk($sformatf("c%0d bp_out_valid", C), out_valid, 1);
        chk($sformatf("c%0d bp_in_ready", C), in_ready, 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("c%0d bp_in_ready_after", C), in_ready, 1);
      chk($sformatf("c%0d bp_out_valid_after", C), out_valid, 0);
      drain();

      // Reset in the second BUSY cycle (DONE for 4 columns per cycle).
      out_ready = 1'b0;
      x = rand128();
      send(x, mc_model(x, 1));
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk($sformatf("c%0d midrst_in_ready", C), in_ready, 0);
      chk($sformatf("c%0d midrst_out_valid", C), out_valid, 0);
      chk($sformatf("c%0d midrst_data_out", C), data_out, '0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("c%0d midrst_in_ready_after", C), in_ready, 1);
      send(KAT_IN, KAT_OUT);
      drain();

      // Round trip through the forward model.
      for (int k = 0; k < 1000; k++) begin
        x = rand128();
        send(mc_model(x, 0), x);
      end
      drain();

      // Streaming with both valid and ready tied high.
      have_last = 0;
      streaming = 1;
      @(posedge clk); #1;
      in_valid = 1'b1;
      data_in  = rand128();
      for (int s = 0; s < 40; s++) begin
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
          @(posedge clk); #1;
          data_in = rand128();
          @(negedge clk);
          w++;
        end
        if (!in_ready) begin
          chk($sformatf("c%0d stream_accept_timeout", C), in_ready, 1);
        end else begin
          exp_q.push_back(mc_model(data_in, 1));
          acc_cyc = cyc;
        end
        @(posedge clk); #1;
        data_in = rand128();
      end
      in_valid = 1'b0;
      drain();
      streaming = 0;
      done_flag[g] = 1'b1;
    end
  end

  initial begin
    int unsigned t = 0;
    chk("model_gmul", gmul(8'h57, 8'h83), 8'hc1);
    chk("model_inv_kat", mc_model(KAT_IN, 1), KAT_OUT);
    chk("model_fwd_kat", mc_model(KAT_OUT, 0), KAT_IN);
    while (!(done_flag[0] && done_flag[1] && done_flag[2]) && t < 40000) begin
      #10;
      t++;
    end
    chk("all_instances_done", {done_flag[0], done_flag[1], done_flag[2]}, 3'b111);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
